// File: rtl/tft_pkg.sv
// Shared constants, widths and state encoding for the TFT write-cursor generator.
package tft_pkg;
  localparam int TFT_COLS  = 800;
  localparam int TFT_ROWS  = 480;
  localparam int TFT_PAGES = 8;

  localparam int COL_W  = 10;
  localparam int ROW_W  = 9;
  localparam int PAGE_W = 3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/tft_cursor_cnt.sv
// Page/row/col write cursor: load beats increment, updates one cycle after inc/load.
// No backpressure; every inc pulse advances the cursor by one pixel.
module tft_cursor_cnt
  import tft_pkg::*;
#(
  parameter int COLS      = TFT_COLS,
  parameter int ROWS      = TFT_ROWS,
  parameter int NUM_PAGES = TFT_PAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [PAGE_W-1:0] load_page,
  input  logic [ROW_W-1:0]  load_row,
  input  logic [COL_W-1:0]  load_col,
  input  logic              page_wrap,
  output logic [PAGE_W-1:0] page,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              last_frame,
  output logic              last_all
);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);
  localparam logic [COL_W-1:0]  COL_ONE   = 1;
  localparam logic [ROW_W-1:0]  ROW_ONE   = 1;
  localparam logic [PAGE_W-1:0] PAGE_ONE  = 1;

  logic col_last;
  logic row_last;
  logic page_last;

  assign col_last   = (col == COL_LAST);
  assign row_last   = (row == ROW_LAST);
  assign page_last  = (page == PAGE_LAST);
  assign last_frame = col_last && row_last;
  assign last_all   = last_frame && page_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page <= '0;
      row  <= '0;
      col  <= '0;
    end else if (load) begin
      page <= load_page;
      row  <= load_row;
      col  <= load_col;
    end else if (inc) begin
      if (!col_last) begin
        col <= col + COL_ONE;
      end else begin
        col <= '0;
        if (!row_last) begin
          row <= row + ROW_ONE;
        end else begin
          row <= '0;
          // Page only advances while clearing; the last page folds back to 0.
          if (page_wrap) page <= page_last ? '0 : page + PAGE_ONE;
        end
      end
    end
  end
endmodule

// File: rtl/tft_wr_addr_gen.sv
// Write-cursor generator: clears all pages at startup, then tracks host writes; 1-cycle registered outputs.
// Commands are accepted every RUN cycle (never in CLEAR) and take priority over a same-cycle increment.
module tft_wr_addr_gen
  import tft_pkg::*;
#(
  parameter int COLS      = TFT_COLS,
  parameter int ROWS      = TFT_ROWS,
  parameter int NUM_PAGES = TFT_PAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startup_inc,
  input  logic              cmd_valid,
  input  logic [PAGE_W-1:0] cmd_page,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [COL_W-1:0]  cmd_col,
  output logic              cmd_ready,
  output logic              cmd_err,
  output logic              startup,
  output logic [PAGE_W-1:0] page_set,
  output logic [ROW_W-1:0]  row_add_user,
  output logic [COL_W-1:0]  col_add_user,
  output logic              frame_done
);
  // One extra bit so a limit equal to 2**width still compares correctly.
  localparam logic [COL_W:0]  COL_LIM  = COLS;
  localparam logic [ROW_W:0]  ROW_LIM  = ROWS;
  localparam logic [PAGE_W:0] PAGE_LIM = NUM_PAGES;

  state_t state;
  state_t state_nxt;

  logic in_range;
  logic cmd_take;
  logic cmd_load;
  logic cnt_inc;
  logic last_frame;
  logic last_all;
  logic cmd_err_nxt;
  logic frame_done_nxt;

  assign in_range = ({1'b0, cmd_col}  < COL_LIM) &&
                    ({1'b0, cmd_row}  < ROW_LIM) &&
                    ({1'b0, cmd_page} < PAGE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      cmd_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cmd_err    <= cmd_err_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cmd_take       = 1'b0;
    cmd_load       = 1'b0;
    cnt_inc        = 1'b0;
    cmd_err_nxt    = 1'b0;
    frame_done_nxt = 1'b0;
    case (state)
      CLEAR: begin
        cnt_inc = startup_inc;
        if (startup_inc && last_all) state_nxt = RUN;
      end
      RUN: begin
        cmd_take = cmd_valid;
        if (cmd_take) begin
          cmd_load    = in_range;
          cmd_err_nxt = !in_range;
        end else begin
          cnt_inc        = startup_inc;
          frame_done_nxt = startup_inc && last_frame;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign startup   = (state == RUN);
  assign cmd_ready = (state == RUN);

  tft_cursor_cnt #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .NUM_PAGES (NUM_PAGES)
  ) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .inc        (cnt_inc),
    .load       (cmd_load),
    .load_page  (cmd_page),
    .load_row   (cmd_row),
    .load_col   (cmd_col),
    .page_wrap  (state == CLEAR),
    .page       (page_set),
    .row        (row_add_user),
    .col        (col_add_user),
    .last_frame (last_frame),
    .last_all   (last_all)
  );
endmodule
